// File: rtl/vco_adc_pkg.sv
// Shared definitions for the VCO ADC conversion sequencer: FSM state
// encoding and channel-index width helpers.
package vco_adc_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CONVERT = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_OUTPUT  = 3'd4;

  localparam int N_CH_DEF = 3;

  // Keeps a channel index at least one bit wide even for a single channel.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_idx_w(N_CH_DEF);

endpackage

// File: rtl/vco_adc_sequencer_if.sv
// Result port of the sequencer: valid/ready handshake carrying a captured
// channel count and the index of the channel it came from.
interface vco_adc_sequencer_if #(
  parameter int DW = 16,
  parameter int CW = 2
);
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [CW-1:0] res_ch;

  modport master (output res_valid, output res_data, output res_ch, input res_ready);
  modport slave  (input res_valid, input res_data, input res_ch, output res_ready);
endinterface

// File: rtl/vco_adc_rr_pick.sv
// Round-robin search: next set mask bit strictly above cur, wrapping to the
// lowest set bit; wrapped flags that the search went past the top.
module vco_adc_rr_pick #(
  parameter int N_CH = 3,
  parameter int CW   = 2
) (
  input  logic [N_CH-1:0] mask,
  input  logic [CW-1:0]   cur,
  output logic [CW-1:0]   next,
  output logic            wrapped
);

  // The second loop overrides the first, so a bit above cur always wins.
  always_comb begin
    next    = cur;
    wrapped = 1'b1;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k <= int'(cur))) next = CW'(k);
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(cur))) begin
        next    = CW'(k);
        wrapped = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vco_adc_sequencer.sv
// Time-multiplexed scheduler for the VCO ADC channels: settle, count window,
// capture and hand each enabled channel's count out on the result port.
module vco_adc_sequencer
  import vco_adc_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int DW         = 16,
  parameter int WW         = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 continuous_i,
  input  logic [N_CH-1:0]      ch_mask_i,
  input  logic [WW-1:0]        window_i,
  output logic [N_CH-1:0]      ch_en_o,
  output logic                 ch_clr_o,
  input  logic [N_CH*DW-1:0]   ch_data_i,
  vco_adc_sequencer_if.master  res,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CW = ch_idx_w(N_CH);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  logic [2:0]      state;
  logic [CW-1:0]   cur;
  logic [N_CH-1:0] mask;
  logic [WW-1:0]   win_len;
  logic            cont;
  logic [SW-1:0]   settle_cnt;
  logic [WW-1:0]   win_cnt;
  logic [DW-1:0]   res_data;
  logic [CW-1:0]   res_ch;

  logic [N_CH-1:0] pick_mask;
  logic [CW-1:0]   pick_cur;
  logic [CW-1:0]   pick_next;
  logic            pick_wrapped;
  logic            handshake;

  // In IDLE, searching from the top index wraps to the lowest set start bit.
  assign pick_mask = (state == ST_IDLE) ? ch_mask_i : mask;
  assign pick_cur  = (state == ST_IDLE) ? CW'(N_CH - 1) : cur;

  vco_adc_rr_pick #(.N_CH(N_CH), .CW(CW)) u_pick (
    .mask    (pick_mask),
    .cur     (pick_cur),
    .next    (pick_next),
    .wrapped (pick_wrapped)
  );

  assign handshake = (state == ST_OUTPUT) && res.res_ready;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      cur        <= '0;
      mask       <= '0;
      win_len    <= '0;
      cont       <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      res_data   <= '0;
      res_ch     <= '0;
    end else if (abort_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i && (|ch_mask_i)) begin
            mask       <= ch_mask_i;
            win_len    <= (window_i == '0) ? WW'(1) : window_i;
            cont       <= continuous_i;
            cur        <= pick_next;
            settle_cnt <= SW'(SETTLE_CYC - 1);
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            win_cnt <= win_len - 1'b1;
            state   <= ST_CONVERT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CONVERT: begin
          if (win_cnt == '0) state <= ST_CAPTURE;
          else win_cnt <= win_cnt - 1'b1;
        end
        ST_CAPTURE: begin
          res_data <= ch_data_i[cur*DW +: DW];
          res_ch   <= cur;
          state    <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (handshake) begin
            if (pick_wrapped && !cont) begin
              state <= ST_IDLE;
            end else begin
              cur        <= pick_next;
              settle_cnt <= SW'(SETTLE_CYC - 1);
              state      <= ST_SETTLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ch_en_o       = ((state == ST_SETTLE) || (state == ST_CONVERT)) ? (N_CH'(1) << cur) : '0;
  assign ch_clr_o      = (state == ST_SETTLE);
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = handshake && pick_wrapped && !cont && !abort_i && !wb_rst_i;
  assign res.res_valid = (state == ST_OUTPUT);
  assign res.res_data  = res_data;
  assign res.res_ch    = res_ch;

endmodule

// File: tb/tb_vco_adc_sequencer.sv
// Self-checking bench for vco_adc_sequencer: phase-timeline reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vco_adc_sequencer;

  localparam int N_CH = 3;
  localparam int DW   = 16;
  localparam int WW   = 16;
  localparam int S    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cont = 1'b0;
  logic             ready = 1'b0;
  logic [N_CH-1:0]  mask_in = '0;
  logic [WW-1:0]    window = '0;
  logic [N_CH*DW-1:0] ch_data = '0;
  logic [N_CH-1:0]  ch_en;
  logic             ch_clr;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_en = -1;
  int first_valid = -1;
  int done_cnt = 0;
  int hs_q[$];

  vco_adc_sequencer_if #(.DW(DW), .CW(2)) res_bus ();

  assign res_bus.res_ready = ready;

  vco_adc_sequencer #(.N_CH(N_CH), .DW(DW), .WW(WW), .SETTLE_CYC(S)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .start_i      (start),
    .abort_i      (abort),
    .continuous_i (cont),
    .ch_mask_i    (mask_in),
    .window_i     (window),
    .ch_en_o      (ch_en),
    .ch_clr_o     (ch_clr),
    .ch_data_i    (ch_data),
    .res          (res_bus.master),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int next_ch(input int cur, input logic [N_CH-1:0] m);
    for (int i = 1; i <= N_CH; i++) begin
      if (m[(cur + i) % N_CH]) return (cur + i) % N_CH;
    end
    return cur;
  endfunction

  // Channel counts change every cycle so a mistimed capture is visible.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N_CH; k++) ch_data[k*DW +: DW] = 16'(cyc * 13 + k * 4097);
    end
  end

  // Reference model: per-channel timeline position m_t since the channel was
  // selected; enable for S+W cycles, capture at S+W, then wait for ready.
  bit              m_on = 1'b0;
  bit              m_act = 1'b0;
  int              m_ch = 0;
  int              m_t = 0;
  int              m_win = 1;
  int              m_nx = 0;
  logic [N_CH-1:0] m_mask = '0;
  bit              m_cont = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  int              m_rch = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_act = 1'b0; m_ch = 0; m_rdata = '0; m_rch = 0;
    end else if (abort) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start && mask_in != '0) begin
        m_act = 1'b1; m_mask = mask_in; m_cont = cont; m_t = 0;
        m_win = (window == '0) ? 1 : int'(window);
        m_ch = next_ch(N_CH - 1, mask_in);
      end
    end else if (m_t < S + m_win + 1) begin
      if (m_t == S + m_win) begin
        m_rdata = ch_data[m_ch*DW +: DW];
        m_rch = m_ch;
      end
      m_t++;
    end else if (ready) begin
      m_nx = next_ch(m_ch, m_mask);
      if (m_nx <= m_ch && !m_cont) m_act = 1'b0;
      else begin
        m_ch = m_nx; m_t = 0;
      end
    end
  end

  logic [N_CH-1:0] exp_en;
  logic            exp_valid;
  logic            exp_done;

  always @(negedge clk) begin
    if (m_on) begin
      exp_en    = (m_act && m_t < S + m_win) ? N_CH'(1 << m_ch) : '0;
      exp_valid = m_act && (m_t == S + m_win + 1);
      exp_done  = exp_valid && ready && !abort && !rst && !m_cont && (next_ch(m_ch, m_mask) <= m_ch);
      check_output("ch_en", ch_en, exp_en);
      check_output("ch_clr", ch_clr, m_act && m_t < S);
      check_output("res_valid", res_bus.res_valid, exp_valid);
      check_output("busy", busy, m_act);
      check_output("done", done, exp_done);
      check_output("res_data", res_bus.res_data, m_rdata);
      check_output("res_ch", res_bus.res_ch, m_rch);
      check_output("en_onehot0", $onehot0(ch_en), 1);
      check_output("en_valid_excl", (|ch_en) && res_bus.res_valid, 0);
      if (res_bus.res_valid && ready) hs_q.push_back(int'(res_bus.res_ch));
      if (done) done_cnt++;
      if (res_bus.res_valid && first_valid < 0) first_valid = cyc;
      if ((|ch_en) && first_en < 0) first_en = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [N_CH-1:0] m, input int w, input bit c);
    tick();
    start = 1'b1; mask_in = m; window = WW'(w); cont = c;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic clear_log();
    hs_q.delete();
    done_cnt = 0;
    first_en = -1;
    first_valid = -1;
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (res_bus.res_valid !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check_output("wait_valid", res_bus.res_valid, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check_output("wait_idle", busy, 0);
  endtask

  task automatic wait_hs(input int cnt, input int lim);
    int n = 0;
    while (hs_q.size() < cnt && n < lim) begin
      @(negedge clk);
      n++;
    end
    check_output("wait_hs", hs_q.size() >= cnt, 1);
  endtask

  task automatic pulse_abort();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_en", ch_en, 0);
    check_output("abort_clr", ch_clr, 0);
    check_output("abort_valid", res_bus.res_valid, 0);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    check_output("rst_en", ch_en, 0);
    check_output("rst_valid", res_bus.res_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_data", res_bus.res_data, 0);

    // Single-shot 3'b101, window 100.
    ready = 1'b1;
    clear_log();
    apply_stimulus(3'b101, 100, 1'b0);
    wait_idle(400);
    check_output("ss_count", hs_q.size(), 2);
    check_output("ss_first_ch", hs_q[0], 0);
    check_output("ss_second_ch", hs_q[1], 2);
    check_output("ss_done_cnt", done_cnt, 1);
    check_output("ss_en_rise", first_en - start_cyc, 0);
    check_output("ss_latency", first_valid - first_en, 109);

    // Backpressure: ready low for 50 cycles with a result waiting.
    ready = 1'b0;
    clear_log();
    apply_stimulus(3'b011, 5, 1'b0);
    wait_valid(100);
    repeat (50) begin
      @(negedge clk);
      check_output("bp_en_off", ch_en, 0);
      check_output("bp_ch", res_bus.res_ch, 0);
    end
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_output("bp_next_en", ch_en, 3'b010);
    wait_valid(100);
    tick();
    ready = 1'b1;
    wait_idle(100);
    check_output("bp_done_cnt", done_cnt, 1);

    // Continuous 3'b111, abort while ch1 is counting.
    clear_log();
    apply_stimulus(3'b111, 3, 1'b1);
    wait_hs(4, 300);
    n = 0;
    tick();
    while (!(ch_en == 3'b010 && !ch_clr) && n < 60) begin
      tick();
      n++;
    end
    check_output("cont_reach_ch1", ch_en, 3'b010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("cont_abort_busy", busy, 0);
    check_output("cont_abort_en", ch_en, 0);
    check_output("cont_order0", hs_q[0], 0);
    check_output("cont_order1", hs_q[1], 1);
    check_output("cont_order2", hs_q[2], 2);
    check_output("cont_order3", hs_q[3], 0);
    check_output("cont_no_done", done_cnt, 0);

    // Window 0 behaves as a one-cycle window.
    clear_log();
    apply_stimulus(3'b001, 0, 1'b0);
    wait_idle(100);
    check_output("w0_latency", first_valid - first_en, 10);

    // Empty mask start is ignored.
    apply_stimulus(3'b000, 5, 1'b0);
    repeat (5) tick();
    check_output("m0_busy", busy, 0);

    // Single channel continuous reconverts itself.
    clear_log();
    apply_stimulus(3'b010, 2, 1'b1);
    wait_hs(3, 200);
    check_output("single_a", hs_q[0], 1);
    check_output("single_b", hs_q[1], 1);
    check_output("single_c", hs_q[2], 1);
    pulse_abort();

    // Reset while a result is pending, then a clean conversion.
    ready = 1'b0;
    apply_stimulus(3'b100, 2, 1'b0);
    wait_valid(100);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mr_valid", res_bus.res_valid, 0);
    check_output("mr_data", res_bus.res_data, 0);
    check_output("mr_ch", res_bus.res_ch, 0);
    check_output("mr_busy", busy, 0);
    ready = 1'b1;
    clear_log();
    apply_stimulus(3'b001, 4, 1'b0);
    wait_idle(100);
    check_output("mr_count", hs_q.size(), 1);
    check_output("mr_ch_after", hs_q[0], 0);

    // Mixed random stimulus against the model.
    repeat (800) begin
      tick();
      start   = ($urandom % 8) == 0;
      abort   = ($urandom % 40) == 0;
      ready   = ($urandom % 2) == 0;
      mask_in = N_CH'($urandom);
      window  = WW'($urandom_range(0, 6));
      cont    = ($urandom % 2) == 0;
    end
    tick();
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b1;
    pulse_abort();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
